// File: rtl/ldm_stm_seq_if.sv
// Bundle of the instruction, beat and base-writeback signals exchanged between
// the EX stage (master) and the LDM/STM sequencer (slave).
interface ldm_stm_seq_if #(
  parameter int AW = 32
);
  logic          i_start;
  logic [15:0]   i_reg_list;
  logic [AW-1:0] i_base_addr;
  logic [3:0]    i_rn_code;
  logic          i_up;
  logic          i_pre;
  logic          i_load;
  logic          i_wb;
  logic          i_mem_ready;

  logic          o_ldm_hold;
  logic          o_busy;
  logic          o_xfer_vld;
  logic          o_xfer_load;
  logic [3:0]    o_xfer_rd;
  logic [AW-1:0] o_xfer_addr;
  logic          o_xfer_last;
  logic          o_wb_base_vld;
  logic [3:0]    o_wb_base_rd;
  logic [AW-1:0] o_wb_base_val;

  modport master (
    output i_start, i_reg_list, i_base_addr, i_rn_code, i_up, i_pre, i_load, i_wb,
           i_mem_ready,
    input  o_ldm_hold, o_busy, o_xfer_vld, o_xfer_load, o_xfer_rd, o_xfer_addr,
           o_xfer_last, o_wb_base_vld, o_wb_base_rd, o_wb_base_val
  );

  modport slave (
    input  i_start, i_reg_list, i_base_addr, i_rn_code, i_up, i_pre, i_load, i_wb,
           i_mem_ready,
    output o_ldm_hold, o_busy, o_xfer_vld, o_xfer_load, o_xfer_rd, o_xfer_addr,
           o_xfer_last, o_wb_base_vld, o_wb_base_rd, o_wb_base_val
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: expands one instruction into ascending
// register/address beats, holds the pipeline meanwhile, and produces the base writeback.
//
// state | meaning
// IDLE  | no instruction in flight; samples i_start
// XFER  | one beat presented per cycle until the last beat is accepted
module ldm_stm_seq #(
  parameter int AW = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ldm_stm_seq_if.slave bus
);

  localparam int NREG = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [NREG-1:0] mask_q;
  logic [AW-1:0]   addr_q;
  logic            load_q;
  logic            wb_req_q;
  logic            rn_hit_q;
  logic [3:0]      rn_q;
  logic [AW-1:0]   wb_val_q;

  logic [4:0]      n_start;
  logic            start_ok;
  logic [AW-1:0]   four_n;
  logic [AW-1:0]   start_raw;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   wb_val_start;
  logic [3:0]      rd_idx;
  logic            last_beat;
  logic            accept;

  logic            hold;
  logic            busy;
  logic            xfer_vld;
  logic            xfer_last;
  logic            wb_vld;

  function automatic logic [4:0] popcount16(input logic [NREG-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < NREG; k++) c = c + {4'b0000, v[k]};
    return c;
  endfunction

  // Start-of-instruction arithmetic; the lowest word of the block is always
  // transferred first, so only the start address depends on U/P.
  always_comb begin
    n_start  = popcount16(bus.i_reg_list);
    start_ok = bus.i_start && (bus.i_reg_list != '0);
    four_n   = {{(AW-7){1'b0}}, n_start, 2'b00};
    unique case ({bus.i_up, bus.i_pre})
      2'b10:   start_raw = bus.i_base_addr;
      2'b11:   start_raw = bus.i_base_addr + AW'(4);
      2'b00:   start_raw = bus.i_base_addr - four_n + AW'(4);
      default: start_raw = bus.i_base_addr - four_n;
    endcase
    start_addr   = {start_raw[AW-1:2], 2'b00};
    wb_val_start = bus.i_up ? (bus.i_base_addr + four_n) : (bus.i_base_addr - four_n);
  end

  always_comb begin
    rd_idx = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (mask_q[k]) rd_idx = 4'(k);
    end
    last_beat = (mask_q != '0) && ((mask_q & (mask_q - 16'd1)) == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hold      = 1'b0;
    busy      = 1'b0;
    xfer_vld  = 1'b0;
    xfer_last = 1'b0;
    accept    = 1'b0;
    wb_vld    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold = start_ok;
        if (start_ok) state_d = XFER;
      end
      XFER: begin
        busy      = 1'b1;
        xfer_vld  = 1'b1;
        xfer_last = last_beat;
        accept    = bus.i_mem_ready;
        hold      = ~(last_beat & bus.i_mem_ready);
        // A load that overwrites Rn keeps the loaded value instead of the writeback.
        wb_vld    = last_beat & bus.i_mem_ready & wb_req_q & ~(load_q & rn_hit_q);
        if (last_beat && bus.i_mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q   <= '0;
      addr_q   <= '0;
      load_q   <= 1'b0;
      wb_req_q <= 1'b0;
      rn_hit_q <= 1'b0;
      rn_q     <= '0;
      wb_val_q <= '0;
    end else if (state_q == IDLE) begin
      if (start_ok) begin
        mask_q   <= bus.i_reg_list;
        addr_q   <= start_addr;
        load_q   <= bus.i_load;
        wb_req_q <= bus.i_wb;
        rn_hit_q <= bus.i_reg_list[bus.i_rn_code];
        rn_q     <= bus.i_rn_code;
        wb_val_q <= wb_val_start;
      end
    end else if (accept) begin
      mask_q <= mask_q & (mask_q - 16'd1);
      addr_q <= addr_q + AW'(4);
    end
  end

  assign bus.o_ldm_hold    = hold;
  assign bus.o_busy        = busy;
  assign bus.o_xfer_vld    = xfer_vld;
  assign bus.o_xfer_load   = xfer_vld & load_q;
  assign bus.o_xfer_rd     = xfer_vld ? rd_idx : 4'd0;
  assign bus.o_xfer_addr   = xfer_vld ? addr_q : '0;
  assign bus.o_xfer_last   = xfer_last;
  assign bus.o_wb_base_vld = wb_vld;
  assign bus.o_wb_base_rd  = rn_q;
  assign bus.o_wb_base_val = wb_val_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: directed cases plus randomized instructions
// checked against a word-block model of LDM/STM.
module tb_ldm_stm_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  ldm_stm_seq_if #(.AW(32)) bus ();

  ldm_stm_seq #(.AW(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] addr;
    logic        load;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
  } wb_t;

  beat_t beat_q[$];
  wb_t   wb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the instruction touches n consecutive words; registers map to them in
  // ascending order starting from the lowest word of the block.
  task automatic model(input logic [15:0] list, input logic [31:0] base, input logic [3:0] rn,
                       input logic up, input logic pre, input logic ld, input logic wb);
    int          n;
    int          i;
    logic [31:0] lowest;
    beat_t       b;
    wb_t         w;
    n = $countones(list);
    if (n == 0) return;
    if (up) lowest = pre ? base + 32'd4 : base;
    else    lowest = pre ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    lowest = lowest & 32'hFFFF_FFFC;
    i = 0;
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        b.rd   = 4'(k);
        b.addr = lowest + 32'(4 * i);
        b.load = ld;
        b.last = (i == n - 1);
        beat_q.push_back(b);
        i++;
      end
    end
    if (wb && !(ld && list[rn])) begin
      w.rd  = rn;
      w.val = up ? base + 32'(4 * n) : base - 32'(4 * n);
      wb_q.push_back(w);
    end
  endtask

  // Monitor: compares every presented beat with the queue head; pops on acceptance.
  always @(negedge clk) begin
    logic  acc;
    logic  wb_exp;
    beat_t e;
    if (!rst) begin
      acc    = bus.o_xfer_vld && bus.i_mem_ready;
      wb_exp = 1'b0;
      chk("busy_vs_vld", {63'd0, bus.o_busy}, {63'd0, bus.o_xfer_vld});
      if (bus.o_xfer_vld) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = beat_q[0];
          chk("beat_rd",   {60'd0, bus.o_xfer_rd},   {60'd0, e.rd});
          chk("beat_addr", {32'd0, bus.o_xfer_addr}, {32'd0, e.addr});
          chk("beat_load", {63'd0, bus.o_xfer_load}, {63'd0, e.load});
          chk("beat_last", {63'd0, bus.o_xfer_last}, {63'd0, e.last});
          chk("hold_xfer", {63'd0, bus.o_ldm_hold},  {63'd0, !(acc && e.last)});
          if (acc) void'(beat_q.pop_front());
          wb_exp = acc && e.last && (wb_q.size() > 0);
        end
      end else if (!bus.i_start) begin
        chk("hold_idle", {63'd0, bus.o_ldm_hold}, 64'd0);
      end
      if (bus.o_xfer_vld || bus.o_wb_base_vld)
        chk("wb_vld", {63'd0, bus.o_wb_base_vld}, {63'd0, wb_exp});
      if (wb_exp) begin
        chk("wb_rd",  {60'd0, bus.o_wb_base_rd},  {60'd0, wb_q[0].rd});
        chk("wb_val", {32'd0, bus.o_wb_base_val}, {32'd0, wb_q[0].val});
        void'(wb_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_hold"},   {63'd0, bus.o_ldm_hold},    64'd0);
    chk({tag, "_busy"},   {63'd0, bus.o_busy},        64'd0);
    chk({tag, "_vld"},    {63'd0, bus.o_xfer_vld},    64'd0);
    chk({tag, "_load"},   {63'd0, bus.o_xfer_load},   64'd0);
    chk({tag, "_rd"},     {60'd0, bus.o_xfer_rd},     64'd0);
    chk({tag, "_addr"},   {32'd0, bus.o_xfer_addr},   64'd0);
    chk({tag, "_last"},   {63'd0, bus.o_xfer_last},   64'd0);
    chk({tag, "_wbvld"},  {63'd0, bus.o_wb_base_vld}, 64'd0);
    chk({tag, "_wbrd"},   {60'd0, bus.o_wb_base_rd},  64'd0);
    chk({tag, "_wbval"},  {32'd0, bus.o_wb_base_val}, 64'd0);
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: stall beat 2 for 3 cycles.
  task automatic run_instr(input logic [15:0] list, input logic [31:0] base, input logic [3:0] rn,
                           input logic up, input logic pre, input logic ld, input logic wb,
                           input int mode, output int cycles);
    @(posedge clk); #1;
    bus.i_start     = 1'b1;
    bus.i_reg_list  = list;
    bus.i_base_addr = base;
    bus.i_rn_code   = rn;
    bus.i_up        = up;
    bus.i_pre       = pre;
    bus.i_load      = ld;
    bus.i_wb        = wb;
    bus.i_mem_ready = 1'b1;
    model(list, base, rn, up, pre, ld, wb);
    @(negedge clk);
    chk("hold_start", {63'd0, bus.o_ldm_hold}, {63'd0, (list != 16'd0)});
    cycles = 0;
    forever begin
      @(posedge clk); #1;
      if (!bus.o_busy) break;
      cycles++;
      bus.i_start    = $urandom_range(0, 1) == 1;
      bus.i_reg_list = 16'($urandom);
      bus.i_up       = 1'($urandom);
      case (mode)
        0:       bus.i_mem_ready = 1'b1;
        1:       bus.i_mem_ready = $urandom_range(0, 3) != 0;
        default: bus.i_mem_ready = !(cycles >= 2 && cycles <= 4);
      endcase
      if (cycles > 300) begin
        chk("timeout", 64'd1, 64'd0);
        break;
      end
    end
    bus.i_start = 1'b0;
    chk("beats_drained", 64'(beat_q.size()), 64'd0);
    chk("wb_drained",    64'(wb_q.size()),   64'd0);
    beat_q.delete();
    wb_q.delete();
  endtask

  initial begin
    int cyc;
    bus.i_start     = 1'b0;
    bus.i_reg_list  = '0;
    bus.i_base_addr = '0;
    bus.i_rn_code   = '0;
    bus.i_up        = 1'b0;
    bus.i_pre       = 1'b0;
    bus.i_load      = 1'b0;
    bus.i_wb        = 1'b0;
    bus.i_mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(16'h000E, 32'h100, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 0, cyc);
    chk("ldmia_cycles", 64'(cyc), 64'd3);
    run_instr(16'h8001, 32'h200, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1, 0, cyc);
    chk("stmdb_cycles", 64'(cyc), 64'd2);
    run_instr(16'h0010, 32'h40, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 0, cyc);
    chk("ldmib_cycles", 64'(cyc), 64'd1);
    run_instr(16'h0007, 32'h300, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 2, cyc);
    chk("stall_cycles", 64'(cyc), 64'd6);
    run_instr(16'h0006, 32'h80, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 0, cyc);
    chk("rn_in_list_cycles", 64'(cyc), 64'd2);
    run_instr(16'h0009, 32'h1000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0, cyc);
    run_instr(16'h0000, 32'h500, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, cyc);
    chk("empty_cycles", 64'(cyc), 64'd0);
    run_instr(16'hFFFF, 32'h0000_0008, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1, cyc);

    // Reset after the first beat of a 4-beat LDM.
    @(posedge clk); #1;
    bus.i_start     = 1'b1;
    bus.i_reg_list  = 16'h00F0;
    bus.i_base_addr = 32'h700;
    bus.i_rn_code   = 4'd1;
    bus.i_up        = 1'b1;
    bus.i_pre       = 1'b0;
    bus.i_load      = 1'b1;
    bus.i_wb        = 1'b1;
    bus.i_mem_ready = 1'b1;
    model(16'h00F0, 32'h700, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete();
    wb_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    run_instr(16'h0011, 32'h900, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, cyc);
    chk("after_abort_cycles", 64'(cyc), 64'd2);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      case ($urandom_range(0, 9))
        0:       lst = 16'd0;
        1:       lst = 16'd1 << $urandom_range(0, 15);
        default: lst = 16'($urandom);
      endcase
      run_instr(lst, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1, cyc);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
